lbdr_route_unit: RTL and testbench

- Parametrised LBDR routing unit for one router input port in an X×Y 2D mesh.
- Computes a one-hot output-port request (N/E/W/S/L) from each HEADER flit at the head of the input FIFO, then holds it for the whole packet until the TAIL flit is read.
- Replaces the fixed-size, partial-port routing logic: all five ports are supported, coordinate widths are generic, and routing/connectivity bits are run-time writable.
- Sits between the input FIFO and the switch allocator.

---
 rtl/noc_pkg.sv | 36 +++
 rtl/lbdr_route_calc.sv | 88 ++++++++
 rtl/lbdr_route_unit.sv | 143 ++++++++++++++
 tb/tb_lbdr_route_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, router port indices, route FSM
// state encoding and a small helper that turns a port index into a one-hot
// request vector.
package noc_pkg;

    // Flit-type codes carried with the head flit of the input FIFO
    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;

    // Router port indices, also the bit positions of the request vector
    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    // Route FSM state encoding
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ROUTED = 1'b1;

    // One-hot request for a cardinal port index (0..3)
    function automatic logic [4:0] port_onehot(input logic [1:0] idx);
        logic [4:0] v;
        v = 5'b00000;
        case (idx)
            2'd0:    v[PORT_N] = 1'b1;
            2'd1:    v[PORT_E] = 1'b1;
            2'd2:    v[PORT_W] = 1'b1;
            2'd3:    v[PORT_S] = 1'b1;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lbdr_route_calc.sv
// LBDR route computation (purely combinational): coordinate comparators,
// the candidate equations qualified by routing (Rxy) and connectivity (Cx)
// bits, priority select L > E > W > N > S, and the optional deroute fallback.
// Optional feature macro: LBDR_DEROUTE_EN (adds the dr input).
module lbdr_route_calc
    import noc_pkg::*;
#(
    parameter int X_W = 2,
    parameter int Y_W = 2
) (
`ifdef LBDR_DEROUTE_EN
    input  logic [1:0]         dr,
`endif
    input  logic [X_W+Y_W-1:0] cur_addr,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic [7:0]         rxy,
    input  logic [3:0]         cx,
    output logic [4:0]         port_sel,
    output logic               port_valid
);

    logic [X_W-1:0] w_x_cur;
    logic [X_W-1:0] w_x_dst;
    logic [Y_W-1:0] w_y_cur;
    logic [Y_W-1:0] w_y_dst;
    logic           w_n1;
    logic           w_e1;
    logic           w_w1;
    logic           w_s1;
    logic           w_cand_n;
    logic           w_cand_e;
    logic           w_cand_w;
    logic           w_cand_s;
    logic           w_cand_l;

    assign w_x_cur = cur_addr[X_W-1:0];
    assign w_x_dst = dst_addr[X_W-1:0];
    assign w_y_cur = cur_addr[X_W +: Y_W];
    assign w_y_dst = dst_addr[X_W +: Y_W];

    // Unsigned direction comparators
    always_comb begin
        w_n1 = (w_y_dst < w_y_cur);
        w_s1 = (w_y_cur < w_y_dst);
        w_e1 = (w_x_cur < w_x_dst);
        w_w1 = (w_x_dst < w_x_cur);
    end

    // Candidate ports: straight moves always allowed, turns gated by Rxy, all gated by Cx
    always_comb begin
        w_cand_n = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & rxy[0]) | (w_n1 & w_w1 & rxy[1])) & cx[0];
        w_cand_e = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & rxy[2]) | (w_e1 & w_s1 & rxy[3])) & cx[1];
        w_cand_w = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & rxy[4]) | (w_w1 & w_s1 & rxy[5])) & cx[2];
        w_cand_s = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & rxy[6]) | (w_s1 & w_w1 & rxy[7])) & cx[3];
        w_cand_l = ~w_n1 & ~w_e1 & ~w_w1 & ~w_s1;
    end

    // Priority select L > E > W > N > S, then deroute fallback if enabled
    always_comb begin
        port_sel   = 5'b00000;
        port_valid = 1'b0;
        if (w_cand_l) begin
            port_sel[PORT_L] = 1'b1;
            port_valid       = 1'b1;
        end else if (w_cand_e) begin
            port_sel[PORT_E] = 1'b1;
            port_valid       = 1'b1;
        end else if (w_cand_w) begin
            port_sel[PORT_W] = 1'b1;
            port_valid       = 1'b1;
        end else if (w_cand_n) begin
            port_sel[PORT_N] = 1'b1;
            port_valid       = 1'b1;
        end else if (w_cand_s) begin
            port_sel[PORT_S] = 1'b1;
            port_valid       = 1'b1;
`ifdef LBDR_DEROUTE_EN
        end else if (cx[dr]) begin
            port_sel   = port_onehot(dr);
            port_valid = 1'b1;
`endif
        end else begin
            port_sel   = 5'b00000;
            port_valid = 1'b0;
        end
    end

endmodule

// File: rtl/lbdr_route_unit.sv
// LBDR routing unit for one router input port. Routes each HEADER flit at
// the FIFO head to a one-hot output-port request and holds that request
// until the packet's TAIL flit is popped. Holds the run-time configuration
// registers (Rxy, Cx, node address), the route FSM and sticky error flags.
// Optional feature macro: LBDR_DEROUTE_EN (adds cfg_dr deroute port index).
module lbdr_route_unit
    import noc_pkg::*;
#(
    parameter int               X_W      = 2,
    parameter int               Y_W      = 2,
    parameter logic [X_W+Y_W-1:0] CUR_ADDR = {(X_W+Y_W){1'b0}},
    parameter logic [7:0]       RXY_INIT = 8'h00,
    parameter logic [3:0]       CX_INIT  = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [2:0]         flit_type,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic               rd_en,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_rxy,
    input  logic [3:0]         cfg_cx,
    input  logic [X_W+Y_W-1:0] cfg_addr,
`ifdef LBDR_DEROUTE_EN
    input  logic [1:0]         cfg_dr,
`endif
    output logic [4:0]         req,
    output logic               busy,
    output logic               err_noroute,
    output logic               err_orphan
);

    logic [7:0]         r_rxy;
    logic [3:0]         r_cx;
    logic [X_W+Y_W-1:0] r_cur_addr;
    logic [0:0]         r_state;
    logic [4:0]         r_req;
    logic               r_err_noroute;
    logic               r_err_orphan;
    logic [4:0]         w_port_sel;
    logic               w_port_valid;
    logic               w_head_valid;
    logic               w_tail_pop;
`ifdef LBDR_DEROUTE_EN
    logic [1:0]         r_dr;
`endif

    assign w_head_valid = ~empty;
    // rd_en with an empty FIFO pops nothing and so never ends a packet
    assign w_tail_pop   = rd_en & ~empty & (flit_type == TAIL);

    lbdr_route_calc #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_calc (
`ifdef LBDR_DEROUTE_EN
        .dr         (r_dr),
`endif
        .cur_addr   (r_cur_addr),
        .dst_addr   (dst_addr),
        .rxy        (r_rxy),
        .cx         (r_cx),
        .port_sel   (w_port_sel),
        .port_valid (w_port_valid)
    );

    // Configuration registers; a header evaluated alongside a write sees the old values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxy      <= RXY_INIT;
            r_cx       <= CX_INIT;
            r_cur_addr <= CUR_ADDR;
        end else if (cfg_we) begin
            r_rxy      <= cfg_rxy;
            r_cx       <= cfg_cx;
            r_cur_addr <= cfg_addr;
        end else begin
            r_rxy      <= r_rxy;
            r_cx       <= r_cx;
            r_cur_addr <= r_cur_addr;
        end
    end

`ifdef LBDR_DEROUTE_EN
    // Deroute port index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr <= 2'd0;
        end else if (cfg_we) begin
            r_dr <= cfg_dr;
        end else begin
            r_dr <= r_dr;
        end
    end
`endif

    // Route FSM: latch a route on a header, hold it until the tail pops; sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_req         <= 5'b00000;
            r_err_noroute <= 1'b0;
            r_err_orphan  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_head_valid && (flit_type == HEADER)) begin
                        if (w_port_valid) begin
                            r_req   <= w_port_sel;
                            r_state <= ROUTED;
                        end else begin
                            r_req         <= 5'b00000;
                            r_err_noroute <= 1'b1;
                        end
                    end else if (w_head_valid && ((flit_type == BODY) || (flit_type == TAIL))) begin
                        r_err_orphan <= 1'b1;
                    end else begin
                        r_req <= 5'b00000;
                    end
                end
                ROUTED: begin
                    if (w_tail_pop) begin
                        r_req   <= 5'b00000;
                        r_state <= IDLE;
                    end else begin
                        r_req <= r_req;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 5'b00000;
                end
            endcase
        end
    end

    assign req         = r_req;
    assign busy        = (r_state == ROUTED);
    assign err_noroute = r_err_noroute;
    assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_lbdr_route_unit.sv
// Self-checking bench for lbdr_route_unit: a behavioural route/packet model
// compared against the DUT on every negative clock edge, plus directed
// literal expectations for the hand-worked cases.
module tb_lbdr_route_unit;

    localparam int         X_W  = 2;
    localparam int         Y_W  = 2;
    localparam logic [3:0] CUR  = 4'b0101;   // y=1, x=1
    localparam logic [2:0] T_HDR  = 3'b001;
    localparam logic [2:0] T_BODY = 3'b010;
    localparam logic [2:0] T_TAIL = 3'b100;

    logic       clk;
    logic       rst;
    logic       empty;
    logic [2:0] flit_type;
    logic [3:0] dst_addr;
    logic       rd_en;
    logic       cfg_we;
    logic [7:0] cfg_rxy;
    logic [3:0] cfg_cx;
    logic [3:0] cfg_addr;
`ifdef LBDR_DEROUTE_EN
    logic [1:0] cfg_dr;
`endif
    logic [4:0] req;
    logic       busy;
    logic       err_noroute;
    logic       err_orphan;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    lbdr_route_unit #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .CUR_ADDR (CUR),
        .RXY_INIT (8'h00),
        .CX_INIT  (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .empty       (empty),
        .flit_type   (flit_type),
        .dst_addr    (dst_addr),
        .rd_en       (rd_en),
        .cfg_we      (cfg_we),
        .cfg_rxy     (cfg_rxy),
        .cfg_cx      (cfg_cx),
        .cfg_addr    (cfg_addr),
`ifdef LBDR_DEROUTE_EN
        .cfg_dr      (cfg_dr),
`endif
        .req         (req),
        .busy        (busy),
        .err_noroute (err_noroute),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference routing: which minimal directions are needed, which are allowed, first by priority
    function automatic logic [4:0] model_route(input logic [3:0] cur, input logic [3:0] dst,
                                               input logic [7:0] rxy, input logic [3:0] cx,
                                               input logic [1:0] dr);
        int  xc, yc, xd, yd;
        bit  go [4];
        bit  ok [4];
        int  order [4];
        logic [4:0] one;
        xc = int'(cur[1:0]); yc = int'(cur[3:2]);
        xd = int'(dst[1:0]); yd = int'(dst[3:2]);
        go[0] = yd < yc; go[1] = xd > xc; go[2] = xd < xc; go[3] = yd > yc;
        order[0] = 1; order[1] = 2; order[2] = 0; order[3] = 3;
        one = 5'b00001;
        if (!(go[0] || go[1] || go[2] || go[3])) return 5'b10000;
        ok[0] = go[0] && (go[1] ? rxy[0] : (go[2] ? rxy[1] : 1'b1));
        ok[1] = go[1] && (go[0] ? rxy[2] : (go[3] ? rxy[3] : 1'b1));
        ok[2] = go[2] && (go[0] ? rxy[4] : (go[3] ? rxy[5] : 1'b1));
        ok[3] = go[3] && (go[1] ? rxy[6] : (go[2] ? rxy[7] : 1'b1));
        for (int k = 0; k < 4; k++)
            if (ok[order[k]] && cx[order[k]]) return one << order[k];
`ifdef LBDR_DEROUTE_EN
        if (cx[dr]) return one << dr;
`endif
        return 5'b00000;
    endfunction

    // Model state
    bit         m_routed;
    logic [4:0] m_req;
    bit         m_nr;
    bit         m_or;
    logic [7:0] m_rxy;
    logic [3:0] m_cx;
    logic [3:0] m_cur;
    logic [1:0] m_dr;
    logic [4:0] m_r;

    // Model update on each clock edge, configuration applied after the header uses old values
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_routed = 1'b0; m_req = 5'b0; m_nr = 1'b0; m_or = 1'b0;
            m_rxy = 8'h00; m_cx = 4'hF; m_cur = CUR; m_dr = 2'd0;
        end else begin
            if (!m_routed) begin
                if (!empty && flit_type == T_HDR) begin
                    m_r = model_route(m_cur, dst_addr, m_rxy, m_cx, m_dr);
                    if (m_r != 5'b0) begin m_req = m_r; m_routed = 1'b1; end
                    else m_nr = 1'b1;
                end else if (!empty && (flit_type == T_BODY || flit_type == T_TAIL)) begin
                    m_or = 1'b1;
                end
            end else if (rd_en && !empty && flit_type == T_TAIL) begin
                m_routed = 1'b0; m_req = 5'b0;
            end
            if (cfg_we) begin
                m_rxy = cfg_rxy; m_cx = cfg_cx; m_cur = cfg_addr;
`ifdef LBDR_DEROUTE_EN
                m_dr = cfg_dr;
`endif
            end
        end
    end

    // Per-cycle comparison of DUT against the model
    always @(negedge clk) begin
        if (started && !rst) begin
            check("model_req", {3'b0, req}, {3'b0, m_req});
            check("model_busy", {7'b0, busy}, {7'b0, m_routed});
            check("model_noroute", {7'b0, err_noroute}, {7'b0, m_nr});
            check("model_orphan", {7'b0, err_orphan}, {7'b0, m_or});
        end
    end

    task automatic idle_inputs();
        empty = 1'b1; flit_type = 3'b000; rd_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic write_cfg(input logic [7:0] rxy, input logic [3:0] cx);
        cfg_rxy = rxy; cfg_cx = cx; cfg_addr = CUR; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Full packet: header, pop, bodies with bubbles, stray header, tail pop
    task automatic run_packet(input string tag, input logic [3:0] dst, input int nbody,
                              input logic [4:0] exp);
        empty = 1'b0; flit_type = T_HDR; dst_addr = dst; rd_en = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        check({tag, "_req"}, {3'b0, req}, {3'b0, exp});
        check({tag, "_busy"}, {7'b0, busy}, 8'd1);
        rd_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < nbody; i++) begin
            empty = 1'b0; flit_type = T_BODY; rd_en = 1'b1;
            @(negedge clk);
            empty = 1'b1; flit_type = T_TAIL; rd_en = 1'b1;
            @(negedge clk);
            check({tag, "_held"}, {3'b0, req}, {3'b0, exp});
        end
        empty = 1'b0; flit_type = T_HDR; dst_addr = CUR; rd_en = 1'b0;
        @(negedge clk);
        check({tag, "_hdr_ignored"}, {3'b0, req}, {3'b0, exp});
        empty = 1'b0; flit_type = T_TAIL; rd_en = 1'b1;
        @(negedge clk);
        idle_inputs();
        check({tag, "_tail_req"}, {3'b0, req}, 8'd0);
        check({tag, "_tail_busy"}, {7'b0, busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; dst_addr = 4'b0; cfg_rxy = 8'h00; cfg_cx = 4'hF; cfg_addr = CUR;
`ifdef LBDR_DEROUTE_EN
        cfg_dr = 2'd0;
`endif
        idle_inputs();
        #2;
        check("rst_req", {3'b0, req}, 8'd0);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_noroute", {7'b0, err_noroute}, 8'd0);
        check("rst_orphan", {7'b0, err_orphan}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);

        // Straight east, then local packet immediately after (bubble cycle)
        run_packet("east", 4'b0111, 1, 5'b00010);
        run_packet("local", CUR, 3, 5'b10000);

        // Turn SE with Rse=1 -> S; write Res=1,Rse=0 in the header cycle -> still S
        write_cfg(8'h40, 4'hF);
        cfg_rxy = 8'h08; cfg_cx = 4'hF; cfg_we = 1'b1;
        run_packet("turn_s", 4'b1110, 1, 5'b01000);
        run_packet("turn_e", 4'b1110, 0, 5'b00010);

        // East disconnected, destination straight east
        write_cfg(8'h08, 4'b1101);
`ifdef LBDR_DEROUTE_EN
        cfg_dr = 2'd3;
        write_cfg(8'h08, 4'b1101);
        run_packet("deroute", 4'b0110, 0, 5'b01000);
        check("deroute_noroute", {7'b0, err_noroute}, 8'd0);
`else
        empty = 1'b0; flit_type = T_HDR; dst_addr = 4'b0110;
        @(negedge clk);
        check("noroute_flag", {7'b0, err_noroute}, 8'd1);
        check("noroute_req", {3'b0, req}, 8'd0);
        check("noroute_busy", {7'b0, busy}, 8'd0);
        idle_inputs();
        @(negedge clk);
`endif
        write_cfg(8'h00, 4'hF);

        // Orphan body while idle, then a normal header
        empty = 1'b0; flit_type = T_BODY;
        @(negedge clk);
        check("orphan_flag", {7'b0, err_orphan}, 8'd1);
        check("orphan_req", {3'b0, req}, 8'd0);
        idle_inputs();
        run_packet("after_orphan", 4'b0100, 1, 5'b00100);

        // Asynchronous reset in the middle of a packet
        empty = 1'b0; flit_type = T_HDR; dst_addr = 4'b0001;
        @(negedge clk);
        check("pre_rst_req", {3'b0, req}, 8'b00000001);
        idle_inputs();
        #3 rst = 1'b1;
        #1;
        check("async_rst_req", {3'b0, req}, 8'd0);
        check("async_rst_busy", {7'b0, busy}, 8'd0);
        check("async_rst_orphan", {7'b0, err_orphan}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        run_packet("post_rst", 4'b0111, 1, 5'b00010);

        @(negedge clk);
        started = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
